// File: rtl/fib_video_pkg.sv
// Shared video timing constants and types for the Fireboy sprite pipeline.
package fib_video_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} fetch_state_t;
  typedef logic [7:0] pal_idx_t;
endpackage

// File: rtl/fireboy_sprite_fetch_if.sv
// Sprite ROM port: the fetcher drives the address and the ROM returns a palette index one clock later.
interface fireboy_sprite_fetch_if #(parameter int ADDR_W = 12);
  import fib_video_pkg::*;

  logic [ADDR_W-1:0] rom_addr;
  pal_idx_t          rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_line_buffer.sv
// One sprite row of palette indices: synchronous write, combinational read.
module sprite_line_buffer
  import fib_video_pkg::*;
#(
  parameter int SPR_W = 32,
  localparam int AW = $clog2(SPR_W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pal_idx_t      wdata,
  input  logic [AW-1:0] raddr,
  output pal_idx_t      rdata
);
  pal_idx_t mem [SPR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SPR_W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fireboy_sprite_fetch.sv
// Fetches the next scanline's Fireboy sprite row during hblank and serves pixels during active video.
//   state | meaning
//   IDLE  | waiting for hblank of a line whose next row intersects the sprite
//   ISSUE | stepping rom_addr across the row, storing data returned one clock late
//   DRAIN | storing the last returned pixel, marking the line valid
module fireboy_sprite_fetch
  import fib_video_pkg::*;
#(
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32,
  parameter int N_FRAMES = 4,
  parameter int ADDR_W   = 12
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] fireboy_x,
  input  logic [9:0] fireboy_y,
  input  logic       facing_left,
  input  logic [1:0] anim_frame,
  fireboy_sprite_fetch_if.master rom,
  output logic       is_fireboy,
  output pal_idx_t   fireboy_data,
  output logic       busy
);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam int FW = $clog2(N_FRAMES);

  fetch_state_t      state, state_n;
  logic [CW-1:0]     col;
  logic [ADDR_W-1:0] addr_q;
  logic              line_valid;
  logic [9:0]        lat_x, lat_y, prev_x, prev_y;
  logic              lat_facing;
  logic [FW-1:0]     lat_frame;

  logic              trig, latch, row_ok;
  logic [9:0]        next_y;
  logic [10:0]       r;
  logic [ADDR_W-1:0] base_addr;

  logic              buf_we;
  logic [CW-1:0]     buf_waddr, pix_col, idx;
  pal_idx_t          buf_wdata, buf_rdata;
  logic              hit;

  assign latch  = (DrawY == 10'(V_ACTIVE)) && (prev_y != 10'(V_ACTIVE));
  assign trig   = (DrawX == 10'(H_ACTIVE)) && (prev_x != 10'(H_ACTIVE));
  assign next_y = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
  // Sign bit of the 11-bit difference rejects lines above the sprite.
  assign r      = {1'b0, next_y} - {1'b0, lat_y};
  assign row_ok = (next_y < 10'(V_ACTIVE)) && !r[10] && (r < 11'(SPR_H));
  assign base_addr = ADDR_W'(lat_frame) * ADDR_W'(SPR_W * SPR_H)
                   + ADDR_W'(r[RW-1:0]) * ADDR_W'(SPR_W);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = col - CW'(1);
    buf_wdata = rom.rom_data;
    case (state)
      IDLE:  if (trig && row_ok) state_n = ISSUE;
      ISSUE: begin
        busy   = 1'b1;
        buf_we = (col != '0);
        if (col == CW'(SPR_W - 1)) state_n = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        buf_we    = 1'b1;
        buf_waddr = CW'(SPR_W - 1);
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      col        <= '0;
      addr_q     <= '0;
      line_valid <= 1'b0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_facing <= 1'b0;
      lat_frame  <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
    end else begin
      prev_x <= DrawX;
      prev_y <= DrawY;
      if (latch) begin
        lat_x      <= fireboy_x;
        lat_y      <= fireboy_y;
        lat_facing <= facing_left;
        lat_frame  <= anim_frame[FW-1:0];
      end
      case (state)
        IDLE: if (trig) begin
          line_valid <= 1'b0;
          if (row_ok) begin
            addr_q <= base_addr;
            col    <= '0;
          end
        end
        ISSUE: begin
          col <= col + CW'(1);
          if (col != CW'(SPR_W - 1)) addr_q <= addr_q + ADDR_W'(1);
        end
        DRAIN:   line_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  assign rom.rom_addr = addr_q;

  sprite_line_buffer #(.SPR_W(SPR_W)) u_buf (
    .clk   (Clk),
    .rst_n (Reset_n),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (buf_wdata),
    .raddr (idx),
    .rdata (buf_rdata)
  );

  // 11-bit compare so a sprite overhanging column 639 clips instead of wrapping.
  assign hit = line_valid && (DrawX < 10'(H_ACTIVE))
            && ({1'b0, DrawX} >= {1'b0, lat_x})
            && ({1'b0, DrawX} < ({1'b0, lat_x} + 11'(SPR_W)));
  assign pix_col = CW'(DrawX - lat_x);
  assign idx     = lat_facing ? (CW'(SPR_W - 1) - pix_col) : pix_col;

  assign is_fireboy   = hit;
  assign fireboy_data = hit ? buf_rdata : 8'h00;
endmodule

// File: tb/tb_fireboy_sprite_fetch.sv
// Directed bench for fireboy_sprite_fetch with a synchronous ROM model whose contents follow rom_f().
module tb_fireboy_sprite_fetch;
  import fib_video_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, fireboy_x = '0, fireboy_y = '0;
  logic       facing_left = 1'b0;
  logic [1:0] anim_frame = '0;
  logic       is_fireboy, busy;
  logic [7:0] fireboy_data;
  int passed = 0;
  int total  = 0;

  fireboy_sprite_fetch_if #(.ADDR_W(12)) rif ();

  fireboy_sprite_fetch #(.SPR_W(32), .SPR_H(32), .N_FRAMES(4), .ADDR_W(12)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .fireboy_x    (fireboy_x),
    .fireboy_y    (fireboy_y),
    .facing_left  (facing_left),
    .anim_frame   (anim_frame),
    .rom          (rif),
    .is_fireboy   (is_fireboy),
    .fireboy_data (fireboy_data),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] rom_f(input int a);
    return 8'(a * 37 + 11);
  endfunction

  always @(posedge Clk) rif.rom_data <= rom_f(int'(rif.rom_addr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input int x, input int y);
    @(posedge Clk); #1;
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
  endtask

  task automatic do_latch(input int x, input int y, input logic face, input int frame);
    fireboy_x   = 10'(x);
    fireboy_y   = 10'(y);
    facing_left = face;
    anim_frame  = 2'(frame);
    drive(0, 480);
  endtask

  // Hblank on line y; expects busy for 33 clocks with rom_addr stepping base..base+31.
  task automatic do_fetch(input string tag, input int y, input int base);
    int n = 0;
    int err = 0;
    drive(640, y);
    @(posedge Clk); #1;
    while (busy && n < 100) begin
      if (rif.rom_addr !== 12'(base + ((n < 31) ? n : 31))) err++;
      @(posedge Clk); #1;
      n++;
    end
    chk({tag, "_busy_len"}, n, 33);
    chk({tag, "_addr_seq"}, err, 0);
  endtask

  initial begin
    int bad;
    int n;
    int xs [5] = '{0, 100, 639, 640, 641};

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_is_fireboy", is_fireboy, 0);
    chk("rst_data", fireboy_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rom_addr", rif.rom_addr, 0);
    Reset_n = 1'b1;

    // Lines 31+ keep next row outside the reset sprite box at lat_y=0.
    bad = 0;
    for (int y = 31; y < 524; y++) begin
      for (int k = 0; k < 5; k++) begin
        drive(xs[k], y);
        if (busy || is_fireboy || fireboy_data != 8'h00) bad++;
      end
    end
    chk("sweep_idle", bad, 0);

    do_latch(100, 50, 1'b0, 0);
    do_fetch("f0", 49, 0);
    for (int k = 0; k < 32; k++) begin
      drive(100 + k, 50);
      chk("f0_hit", is_fireboy, 1);
      chk("f0_pix", fireboy_data, rom_f(k));
    end
    drive(99, 50);
    chk("f0_left_miss", is_fireboy, 0);
    drive(132, 50);
    chk("f0_right_miss", is_fireboy, 0);
    chk("f0_right_data", fireboy_data, 0);

    do_latch(100, 50, 1'b1, 0);
    do_fetch("mir", 49, 0);
    drive(100, 50);
    chk("mir_first", fireboy_data, rom_f(31));
    drive(131, 50);
    chk("mir_last", fireboy_data, rom_f(0));

    // Frame 2, row 5: 2*1024 + 5*32 = 2208.
    do_latch(100, 50, 1'b0, 2);
    do_fetch("fr2", 54, 2208);
    drive(100, 55);
    chk("fr2_first", fireboy_data, rom_f(2208));
    drive(131, 55);
    chk("fr2_last", fireboy_data, rom_f(2239));

    do_latch(620, 50, 1'b0, 0);
    do_fetch("edge", 49, 0);
    drive(620, 50);
    chk("edge_620_hit", is_fireboy, 1);
    chk("edge_620_pix", fireboy_data, rom_f(0));
    drive(639, 50);
    chk("edge_639_pix", fireboy_data, rom_f(19));
    drive(640, 50);
    chk("edge_640_miss", is_fireboy, 0);
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
    end while (busy && n < 60);
    chk("edge_refetch_done", busy, 0);
    drive(625, 51);
    chk("edge_row1_pix", fireboy_data, rom_f(37));
    drive(0, 51);
    chk("edge_nowrap_0", is_fireboy, 0);
    drive(11, 51);
    chk("edge_nowrap_11", is_fireboy, 0);

    do_latch(100, 50, 1'b0, 0);
    drive(640, 49);
    @(posedge Clk); #1;
    repeat (10) @(posedge Clk);
    #1;
    chk("abort_busy_before", busy, 1);
    Reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_is_fireboy", is_fireboy, 0);
    chk("abort_rom_addr", rif.rom_addr, 0);
    Reset_n = 1'b1;
    drive(100, 50);
    chk("abort_line_miss", is_fireboy, 0);

    // Latched values are back to zero: sprite box is columns 0..31, rows 0..31.
    do_fetch("post", 0, 32);
    drive(0, 1);
    chk("post_first", fireboy_data, rom_f(32));
    drive(31, 1);
    chk("post_last", fireboy_data, rom_f(63));
    drive(32, 1);
    chk("post_miss", is_fireboy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
